coeff_commit_sync: RTL and testbench
====================================

Name: coeff_commit_sync

Overview:
- Multi-channel, parametrised coefficient-commit synchroniser for the equaliser datapath.
- Per band: captures the rising edge of that band's register-file write-done and holds it as a pending update. Releases it as a one-cycle coefficient-load enable only at the commit phase of the filter frame, so coefficients never change mid-MAC sweep.
- Adds an atomic group-commit mode, overrun detection and a commit counter.

Parameters:
NUM_CH, 8, number of bands/channels
PHASE_W, 6, width of the phase counter input
COMMIT_PHASE, 63, phase value at which pending updates commit
CNT_W, 8, width of commit event counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
clk_enable  in  1  global advance enable; every register updates only when 1
i_write_done  in  NUM_CH  per-channel write-done level from input registers
i_phase  in  PHASE_W  current filter phase from the phase checker
i_atomic  in  1  0 = independent commit, 1 = group commit
i_group_mask  in  NUM_CH  channels forming the atomic group
i_clear_ovr  in  1  clears o_overrun (synchronous, on clk_enable)
o_pending  out  NUM_CH  captured, not yet committed updates
o_coeffs_en  out  NUM_CH  one-enabled-cycle coefficient load strobe
o_overrun  out  NUM_CH  sticky: second write-done edge arrived while pending
o_busy  out  1  OR of o_pending
o_commit_cnt  out  CNT_W  count of commit events, wraps

Behaviour:
- Reset (async, rst=1): o_pending, o_coeffs_en, o_overrun, o_commit_cnt = 0; edge-history register = 0. Consequence: a write-done already high when rst falls counts as an edge on the first enabled cycle.
- clk_enable=0: all state and outputs hold. o_coeffs_en stays at its last value. Strobe width is one enabled cycle, not one clk.
- Edge detect: edge[c] = i_write_done[c] & ~prev[c]. prev <= i_write_done on each enabled cycle. A level held high yields exactly one edge.
- Commit cycle: enabled cycle with i_phase == COMMIT_PHASE.
- Commit set, independent mode (i_atomic=0): commit[c] = commit cycle & o_pending[c].
- Commit set, atomic mode (i_atomic=1):
  - For c in i_group_mask: commit[c] = commit cycle & all masked pending bits set. A partial group waits in pending.
  - Unmasked channels behave as in independent mode.
  - i_group_mask = 0 makes atomic mode identical to independent mode.
- Per-channel next state (one enabled cycle):
  - o_coeffs_en[c] <= commit[c]
  - o_pending[c] <= (o_pending[c] & ~commit[c]) | edge[c]
  - o_overrun[c] <= (o_overrun[c] & ~i_clear_ovr) | (edge[c] & o_pending[c] & ~commit[c])
- Simultaneous events:
  - Edge in the same cycle as that channel's commit: old update commits, new one re-arms pending, no overrun.
  - Overrun set and i_clear_ovr in the same cycle: set wins.
- Latency:
  - Write-done edge sampled in enabled cycle n: o_pending high after cycle n.
  - Earliest strobe: edge at n, commit phase at n+1; o_coeffs_en high after n+1.
  - Edge sampled in the commit cycle itself: waits one full frame.
- o_commit_cnt increments by 1 (mod 2^CNT_W) after any enabled cycle where commit is nonzero. One increment per cycle regardless of how many channels commit.
- o_busy is combinational OR of registered o_pending.
- Reset mid-operation: pending updates are discarded, with no strobe issued.

Test Plan:
- Reset release with i_write_done=8'h00, then pulse ch2 at phase 10, clk_enable=1 -> o_pending=8'h04 and o_busy=1 next cycle; at phase 63 o_coeffs_en=8'h04 for one cycle; pending cleared; o_commit_cnt=1.
- Hold ch0 write-done high across 3 frames -> exactly one o_coeffs_en[0] strobe; o_overrun[0]=0.
- Ch5 edges at phase 20 and phase 40 of the same frame -> o_overrun=8'h20 sticky; one strobe at 63. Then i_clear_ovr=1 -> o_overrun=0.
- Atomic: i_atomic=1, i_group_mask=8'h0F. Ch0..2 written in frame 1, ch3 in frame 2 -> no strobe at frame-1 phase 63; o_coeffs_en=8'h0F at frame-2 phase 63; commit_cnt +1.
- Edge on ch1 exactly at phase 63 while pending -> o_coeffs_en[1]=1, o_pending[1] stays 1, o_overrun[1]=0. Next frame strobes again.
- clk_enable toggling 1-0-0-1 around the commit cycle -> strobe persists through the disabled cycles, drops on the next enabled cycle. Async rst asserted while pending=8'hFF -> all outputs 0 immediately, no strobe afterwards.

Source files
------------

// File: rtl/coeff_commit_sync.sv
// Per-band coefficient commit synchroniser: latches register-file write-done edges as
// pending updates and releases them as load strobes only at the frame commit phase.
module coeff_commit_sync #(
    parameter int NUM_CH       = 8,
    parameter int PHASE_W      = 6,
    parameter int COMMIT_PHASE = 63,
    parameter int CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_enable,
    input  logic [NUM_CH-1:0]  i_write_done,
    input  logic [PHASE_W-1:0] i_phase,
    input  logic               i_atomic,
    input  logic [NUM_CH-1:0]  i_group_mask,
    input  logic               i_clear_ovr,
    output logic [NUM_CH-1:0]  o_pending,
    output logic [NUM_CH-1:0]  o_coeffs_en,
    output logic [NUM_CH-1:0]  o_overrun,
    output logic               o_busy,
    output logic [CNT_W-1:0]   o_commit_cnt
);

    logic [NUM_CH-1:0] wd_prev;
    logic [NUM_CH-1:0] wd_edge;
    logic [NUM_CH-1:0] commit;
    logic              commit_cycle;
    logic              group_ready;

    // A partially written atomic group is held back; unmasked bands commit freely.
    always_comb begin
        wd_edge      = i_write_done & ~wd_prev;
        commit_cycle = clk_enable && (i_phase == PHASE_W'(COMMIT_PHASE));
        group_ready  = &(o_pending | ~i_group_mask);
        commit       = '0;
        if (commit_cycle) begin
            commit = o_pending;
            if (i_atomic && !group_ready) begin
                commit = o_pending & ~i_group_mask;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_prev      <= '0;
            o_pending    <= '0;
            o_coeffs_en  <= '0;
            o_overrun    <= '0;
            o_commit_cnt <= '0;
        end else if (clk_enable) begin
            wd_prev     <= i_write_done;
            o_coeffs_en <= commit;
            o_pending   <= (o_pending & ~commit) | wd_edge;
            o_overrun   <= (o_overrun & {NUM_CH{~i_clear_ovr}})
                         | (wd_edge & o_pending & ~commit);
            if (|commit) begin
                o_commit_cnt <= o_commit_cnt + CNT_W'(1);
            end
        end
    end

    assign o_busy = |o_pending;

endmodule

// File: tb/tb_coeff_commit_sync.sv
// Self-checking bench for coeff_commit_sync: directed scenarios plus a randomized run
// compared against a per-band behavioural model.
module tb_coeff_commit_sync;

    localparam int NUM_CH = 8;
    localparam int CNT_W  = 8;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] wd;
    logic [5:0] phase;
    logic       atomic;
    logic [7:0] mask;
    logic       clr;
    logic [7:0] o_pending;
    logic [7:0] o_coeffs_en;
    logic [7:0] o_overrun;
    logic       o_busy;
    logic [7:0] o_commit_cnt;

    int total = 0;
    int bad   = 0;

    bit m_pend [NUM_CH];
    bit m_prev [NUM_CH];
    bit m_ovr  [NUM_CH];
    bit m_en   [NUM_CH];
    int m_cnt;

    coeff_commit_sync #(
        .NUM_CH(NUM_CH), .PHASE_W(6), .COMMIT_PHASE(63), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .clk_enable(en), .i_write_done(wd), .i_phase(phase),
        .i_atomic(atomic), .i_group_mask(mask), .i_clear_ovr(clr),
        .o_pending(o_pending), .o_coeffs_en(o_coeffs_en), .o_overrun(o_overrun),
        .o_busy(o_busy), .o_commit_cnt(o_commit_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_pend[c] = 0; m_prev[c] = 0; m_ovr[c] = 0; m_en[c] = 0;
        end
        m_cnt = 0;
    endfunction

    // Band-level rules: an update waits for the commit phase, and a group waits for all members.
    function automatic void model_clock();
        bit group_full;
        bit any_commit;
        bit cm [NUM_CH];
        bit ed [NUM_CH];
        group_full = 1;
        any_commit = 0;
        if (!en) return;
        for (int c = 0; c < NUM_CH; c++)
            if (mask[c] && !m_pend[c]) group_full = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            ed[c] = wd[c] && !m_prev[c];
            cm[c] = (phase == 63) && m_pend[c] && (!(atomic && mask[c]) || group_full);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            m_ovr[c]  = (ed[c] && m_pend[c] && !cm[c]) || (m_ovr[c] && !clr);
            m_pend[c] = ed[c] || (m_pend[c] && !cm[c]);
            m_en[c]   = cm[c];
            m_prev[c] = wd[c];
            if (cm[c]) any_commit = 1;
        end
        if (any_commit) m_cnt = (m_cnt + 1) % 256;
    endfunction

    function automatic logic [7:0] pk(input int which);
        logic [7:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            case (which)
                0:       v[c] = m_pend[c];
                1:       v[c] = m_en[c];
                default: v[c] = m_ovr[c];
            endcase
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic tick_adv();
        tick();
        phase = phase + 6'd1;
    endtask

    task automatic to_phase(input logic [5:0] p);
        while (phase != p) tick_adv();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        wd = '0; phase = '0; atomic = 1'b0; mask = '0; clr = 1'b0; en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({o_pending, o_coeffs_en, o_overrun, o_busy, o_commit_cnt} !== 33'd0) begin
            bad++;
            $display("[TB] FAIL reset_state: got %h/%h/%h/%b/%0d want all zero",
                     o_pending, o_coeffs_en, o_overrun, o_busy, o_commit_cnt);
        end
    endtask

    task automatic test_single();
        apply_reset();
        to_phase(6'd10);
        wd = 8'h04; tick_adv(); wd = 8'h00;
        total++;
        if (o_pending !== 8'h04 || o_busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_pending: got %h busy %b want 04 busy 1", o_pending, o_busy);
        end
        to_phase(6'd63);
        tick_adv();
        total++;
        if (o_coeffs_en !== 8'h04 || o_pending !== 8'h00 || o_commit_cnt !== 8'd1) begin
            bad++;
            $display("[TB] FAIL single_commit: got en %h pend %h cnt %0d want 04 00 1",
                     o_coeffs_en, o_pending, o_commit_cnt);
        end
        tick_adv();
        total++;
        if (o_coeffs_en !== 8'h00 || o_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_strobe_drop: got en %h busy %b want 00 0", o_coeffs_en, o_busy);
        end
    endtask

    task automatic test_hold_level();
        int strobes;
        strobes = 0;
        apply_reset();
        wd = 8'h01;
        repeat (192) begin
            tick_adv();
            if (o_coeffs_en[0]) strobes++;
        end
        wd = 8'h00;
        total++;
        if (strobes != 1 || o_overrun !== 8'h00) begin
            bad++;
            $display("[TB] FAIL hold_level: got strobes %0d ovr %h want 1 00", strobes, o_overrun);
        end
    endtask

    task automatic test_overrun();
        apply_reset();
        to_phase(6'd20);
        wd = 8'h20; tick_adv(); wd = 8'h00;
        to_phase(6'd40);
        wd = 8'h20; tick_adv(); wd = 8'h00;
        total++;
        if (o_overrun !== 8'h20) begin
            bad++;
            $display("[TB] FAIL overrun_set: got %h want 20", o_overrun);
        end
        to_phase(6'd63);
        tick_adv();
        total++;
        if (o_coeffs_en !== 8'h20 || o_overrun !== 8'h20 || o_pending !== 8'h00) begin
            bad++;
            $display("[TB] FAIL overrun_commit: got en %h ovr %h pend %h want 20 20 00",
                     o_coeffs_en, o_overrun, o_pending);
        end
        clr = 1'b1; tick_adv(); clr = 1'b0;
        total++;
        if (o_overrun !== 8'h00) begin
            bad++;
            $display("[TB] FAIL overrun_clear: got %h want 00", o_overrun);
        end
    endtask

    task automatic test_atomic();
        apply_reset();
        atomic = 1'b1; mask = 8'h0F;
        to_phase(6'd5);
        wd = 8'h07; tick_adv(); wd = 8'h00;
        to_phase(6'd63);
        tick_adv();
        total++;
        if (o_coeffs_en !== 8'h00 || o_pending !== 8'h07 || o_commit_cnt !== 8'd0) begin
            bad++;
            $display("[TB] FAIL atomic_partial: got en %h pend %h cnt %0d want 00 07 0",
                     o_coeffs_en, o_pending, o_commit_cnt);
        end
        to_phase(6'd5);
        wd = 8'h08; tick_adv(); wd = 8'h00;
        to_phase(6'd63);
        tick_adv();
        total++;
        if (o_coeffs_en !== 8'h0F || o_pending !== 8'h00 || o_commit_cnt !== 8'd1) begin
            bad++;
            $display("[TB] FAIL atomic_group: got en %h pend %h cnt %0d want 0f 00 1",
                     o_coeffs_en, o_pending, o_commit_cnt);
        end
        atomic = 1'b0; mask = 8'h00;
    endtask

    task automatic test_edge_at_commit();
        apply_reset();
        to_phase(6'd10);
        wd = 8'h02; tick_adv(); wd = 8'h00;
        to_phase(6'd63);
        wd = 8'h02; tick_adv(); wd = 8'h00;
        total++;
        if (o_coeffs_en[1] !== 1'b1 || o_pending[1] !== 1'b1 || o_overrun[1] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL edge_at_commit: got en %b pend %b ovr %b want 1 1 0",
                     o_coeffs_en[1], o_pending[1], o_overrun[1]);
        end
        to_phase(6'd63);
        tick_adv();
        total++;
        if (o_coeffs_en !== 8'h02 || o_pending !== 8'h00 || o_commit_cnt !== 8'd2) begin
            bad++;
            $display("[TB] FAIL edge_next_frame: got en %h pend %h cnt %0d want 02 00 2",
                     o_coeffs_en, o_pending, o_commit_cnt);
        end
    endtask

    task automatic test_enable_gap();
        apply_reset();
        to_phase(6'd30);
        wd = 8'h08; tick_adv(); wd = 8'h00;
        to_phase(6'd63);
        tick_adv();
        total++;
        if (o_coeffs_en !== 8'h08) begin
            bad++;
            $display("[TB] FAIL enable_strobe: got %h want 08", o_coeffs_en);
        end
        en = 1'b0;
        tick();
        tick();
        total++;
        if (o_coeffs_en !== 8'h08 || o_commit_cnt !== 8'd1) begin
            bad++;
            $display("[TB] FAIL enable_hold: got en %h cnt %0d want 08 1", o_coeffs_en, o_commit_cnt);
        end
        en = 1'b1;
        tick_adv();
        total++;
        if (o_coeffs_en !== 8'h00) begin
            bad++;
            $display("[TB] FAIL enable_drop: got %h want 00", o_coeffs_en);
        end
    endtask

    task automatic test_reset_mid();
        int strobes;
        strobes = 0;
        apply_reset();
        to_phase(6'd12);
        wd = 8'hFF; tick_adv(); wd = 8'h00;
        total++;
        if (o_pending !== 8'hFF) begin
            bad++;
            $display("[TB] FAIL mid_pending: got %h want ff", o_pending);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        total++;
        if ({o_pending, o_coeffs_en, o_overrun, o_busy, o_commit_cnt} !== 33'd0) begin
            bad++;
            $display("[TB] FAIL mid_async_reset: got %h/%h/%h/%b/%0d want all zero",
                     o_pending, o_coeffs_en, o_overrun, o_busy, o_commit_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (70) begin
            tick_adv();
            if (o_coeffs_en != 8'h00) strobes++;
        end
        total++;
        if (strobes != 0) begin
            bad++;
            $display("[TB] FAIL mid_no_strobe: got %0d strobes want 0", strobes);
        end
    endtask

    task automatic test_random();
        logic [32:0] exp_v;
        apply_reset();
        for (int i = 0; i < 2000; i++) begin
            if (i % 250 == 0) begin
                atomic = 1'($urandom_range(0, 1));
                mask   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            end
            wd  = wd ^ 8'($urandom & $urandom & $urandom);
            en  = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 15) == 0);
            tick();
            if (en) phase = ($urandom_range(0, 15) == 0) ? 6'd62 : phase + 6'd1;
            exp_v = {pk(0), pk(1), pk(2), (pk(0) != 8'h00), 8'(m_cnt)};
            total++;
            if ({o_pending, o_coeffs_en, o_overrun, o_busy, o_commit_cnt} !== exp_v) begin
                bad++;
                $display("[TB] FAIL random_cycle%0d: got %h want %h", i,
                         {o_pending, o_coeffs_en, o_overrun, o_busy, o_commit_cnt}, exp_v);
            end
        end
        en = 1'b1; clr = 1'b0; wd = 8'h00;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; wd = '0; phase = '0; atomic = 1'b0; mask = '0; clr = 1'b0;
        model_reset();
        #1;
        $display("[TB] starting coeff_commit_sync tests");
        test_reset();
        test_single();
        test_hold_level();
        test_overrun();
        test_atomic();
        test_edge_at_commit();
        test_enable_gap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
